// File: rtl/anti_replay_window.sv
// Multi-channel anti-replay validator: per-channel sliding-window counter check plus a
// nonce cache searched one entry per cycle behind a BUSY/DONE status handshake.
module anti_replay_window #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int WINDOW      = 32,
    parameter int NONCE_W     = 32,
    parameter int NONCE_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int IDX_W  = $clog2(NONCE_DEPTH);
    localparam int CNTC_W = $clog2(NONCE_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_COMMIT} state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_ch_sel;
    logic [CNT_W-1:0]    r_check_cnt;
    logic [NONCE_W-1:0]  r_check_nonce;
    logic                r_valid, r_replay, r_bad_cnt, r_bad_nonce;
    logic                r_busy, r_done, r_overrun;

    logic [CH_W-1:0]     r_snap_ch;
    logic [CNT_W-1:0]    r_snap_cnt;
    logic [NONCE_W-1:0]  r_snap_nonce;
    logic [IDX_W-1:0]    r_idx;
    logic                r_match;

    logic [CNT_W-1:0]    r_high   [CHANNELS];
    logic [WINDOW-1:0]   r_bitmap [CHANNELS];
    logic [NONCE_W-1:0]  r_cache  [CHANNELS][NONCE_DEPTH];
    logic [IDX_W-1:0]    r_head   [CHANNELS];
    logic [CNTC_W-1:0]   r_count  [CHANNELS];

    logic                w_idle, w_validate;
    logic [CNT_W-1:0]    w_high, w_diff, w_shift;
    logic [WINDOW-1:0]   w_bmp, w_bmp_next;
    logic                w_newer, w_bad_cnt, w_bad, w_hit, w_last;

    assign w_idle     = (r_state == S_IDLE);
    assign w_validate = we && (addr == 6'h0C);

    // Counter verdict for the snapshotted channel; only meaningful in COMMIT.
    assign w_high     = r_high[r_snap_ch];
    assign w_bmp      = r_bitmap[r_snap_ch];
    assign w_newer    = (r_snap_cnt > w_high);
    assign w_diff     = w_high - r_snap_cnt;
    assign w_shift    = r_snap_cnt - w_high;
    assign w_bad_cnt  = (r_snap_cnt == '0) ||
                        (!w_newer && ((w_diff >= CNT_W'(WINDOW)) ||
                                      (|(w_bmp & (WINDOW'(1) << w_diff)))));
    assign w_bad      = w_bad_cnt || r_match;
    assign w_bmp_next = w_newer ? ((w_shift >= CNT_W'(WINDOW)) ? WINDOW'(1)
                                                               : ((w_bmp << w_shift) | WINDOW'(1)))
                                : (w_bmp | (WINDOW'(1) << w_diff));

    assign w_hit  = (r_cache[r_snap_ch][r_idx] == r_snap_nonce);
    assign w_last = (CNTC_W'(r_idx) == (r_count[r_snap_ch] - CNTC_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_ch_sel      <= '0;
            r_check_cnt   <= '0;
            r_check_nonce <= '0;
            r_valid       <= 1'b0;
            r_replay      <= 1'b0;
            r_bad_cnt     <= 1'b0;
            r_bad_nonce   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_snap_ch     <= '0;
            r_snap_cnt    <= '0;
            r_snap_nonce  <= '0;
            r_idx         <= '0;
            r_match       <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_high[i]   <= '0;
                r_bitmap[i] <= '0;
                r_head[i]   <= '0;
                r_count[i]  <= '0;
                for (int j = 0; j < NONCE_DEPTH; j++) r_cache[i][j] <= '0;
            end
        end else begin
            // Configuration and CTRL writes only take effect while no validation is in flight.
            if (we && w_idle) begin
                case (addr)
                    6'h00: r_ch_sel <= (wdata >= 32'(CHANNELS)) ? CH_W'(CHANNELS - 1) : CH_W'(wdata);
                    6'h04: r_check_cnt <= wdata[CNT_W-1:0];
                    6'h08: r_check_nonce <= wdata[NONCE_W-1:0];
                    6'h20: begin
                        if (wdata[0]) begin
                            r_head[r_ch_sel]  <= '0;
                            r_count[r_ch_sel] <= '0;
                            for (int j = 0; j < NONCE_DEPTH; j++) r_cache[r_ch_sel][j] <= '0;
                        end
                        if (wdata[1]) begin
                            r_high[r_ch_sel]   <= '0;
                            r_bitmap[r_ch_sel] <= '0;
                        end
                        if (wdata[2]) begin
                            for (int i = 0; i < CHANNELS; i++) begin
                                r_high[i]   <= '0;
                                r_bitmap[i] <= '0;
                                r_head[i]   <= '0;
                                r_count[i]  <= '0;
                                for (int j = 0; j < NONCE_DEPTH; j++) r_cache[i][j] <= '0;
                            end
                            r_valid     <= 1'b0;
                            r_replay    <= 1'b0;
                            r_bad_cnt   <= 1'b0;
                            r_bad_nonce <= 1'b0;
                            r_done      <= 1'b0;
                            r_overrun   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (w_validate) begin
                        r_snap_ch    <= r_ch_sel;
                        r_snap_cnt   <= r_check_cnt;
                        r_snap_nonce <= r_check_nonce;
                        r_valid      <= 1'b0;
                        r_replay     <= 1'b0;
                        r_bad_cnt    <= 1'b0;
                        r_bad_nonce  <= 1'b0;
                        r_done       <= 1'b0;
                        r_overrun    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_match      <= 1'b0;
                        r_idx        <= '0;
                        r_state      <= (r_count[r_ch_sel] == '0) ? S_COMMIT : S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_hit) begin
                        r_match <= 1'b1;
                        r_state <= S_COMMIT;
                    end else if (w_last) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                S_COMMIT: begin
                    r_valid     <= !w_bad;
                    r_replay    <= w_bad;
                    r_bad_cnt   <= w_bad_cnt;
                    r_bad_nonce <= r_match;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_IDLE;
                    if (!w_bad) begin
                        if (w_newer) r_high[r_snap_ch] <= r_snap_cnt;
                        r_bitmap[r_snap_ch]            <= w_bmp_next;
                        r_cache[r_snap_ch][r_head[r_snap_ch]] <= r_snap_nonce;
                        r_head[r_snap_ch] <= r_head[r_snap_ch] + IDX_W'(1);
                        if (r_count[r_snap_ch] != CNTC_W'(NONCE_DEPTH))
                            r_count[r_snap_ch] <= r_count[r_snap_ch] + CNTC_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_validate && !w_idle) r_overrun <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            6'h00: rdata = 32'(r_ch_sel);
            6'h04: rdata = 32'(r_check_cnt);
            6'h08: rdata = 32'(r_check_nonce);
            6'h10: rdata = 32'({r_overrun, r_done, r_busy, r_bad_nonce, r_bad_cnt, r_replay, r_valid});
            6'h14: rdata = 32'(r_high[r_ch_sel]);
            6'h18: rdata = 32'(r_bitmap[r_ch_sel]);
            6'h1C: rdata = 32'(r_count[r_ch_sel]);
            default: rdata = '0;
        endcase
    end
endmodule
